// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with single-cycle hits
// and a request/ready main-memory port for write-back and refill.
module data_cache #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int CACHE_SIZE       = 16,
  parameter int CACHE_INDEX_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cache_vis_signal,
  input  logic [ADDR_WIDTH-1:0] mem_vis_addr,
  input  logic [2:0]            d_cache_data_type,
  input  logic [LEN-1:0]        cache_written_data,
  input  logic [3:0]            write_length,
  output logic [LEN-1:0]        mem_data,
  output logic [1:0]            d_cache_status,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-3:0] ram_addr,
  output logic [LEN-1:0]        ram_wdata,
  input  logic [LEN-1:0]        ram_rdata,
  input  logic                  ram_ready
);
  localparam logic [1:0] D_CACHE_LOAD    = 2'd1;
  localparam logic [1:0] D_CACHE_STORE   = 2'd2;
  localparam logic [1:0] D_CACHE_RESTING = 2'd0;
  localparam logic [1:0] D_CACHE_STALL   = 2'd1;
  localparam logic [2:0] ONE_BYTE        = 3'd0;
  localparam logic [2:0] TWO_BYTE        = 3'd1;
  localparam int         TAG_W           = ADDR_WIDTH - CACHE_INDEX_SIZE - 2;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, REFILL = 2'd2} state_t;
  state_t state, state_next;

  logic [CACHE_SIZE-1:0]       valid, dirty;
  logic [TAG_W-1:0]            tags  [CACHE_SIZE];
  logic [LEN-1:0]              lines [CACHE_SIZE];
  logic [TAG_W-1:0]            miss_tag;
  logic [CACHE_INDEX_SIZE-1:0] miss_index;

  logic [CACHE_INDEX_SIZE-1:0] req_index;
  logic [TAG_W-1:0]            req_tag;
  logic [1:0]                  req_offset;
  logic                        req_active, hit, load_hit, store_hit, miss;
  logic [4:0]                  lane_shift;
  logic [LEN-1:0]              lane_mask, line_word, load_value, store_value;
  logic                        unused_inputs;

  assign unused_inputs = ^write_length;

  assign req_offset = mem_vis_addr[1:0];
  assign req_index  = mem_vis_addr[CACHE_INDEX_SIZE+1:2];
  assign req_tag    = mem_vis_addr[ADDR_WIDTH-1:CACHE_INDEX_SIZE+2];
  assign req_active = rst_n && (state == IDLE) &&
                      (cache_vis_signal == D_CACHE_LOAD || cache_vis_signal == D_CACHE_STORE);
  assign hit        = valid[req_index] && (tags[req_index] == req_tag);
  assign load_hit   = req_active && hit && (cache_vis_signal == D_CACHE_LOAD);
  assign store_hit  = req_active && hit && (cache_vis_signal == D_CACHE_STORE);
  assign miss       = req_active && !hit;

  // Natural alignment: halfwords ignore offset[0], words ignore the whole offset.
  always_comb begin
    lane_shift = '0;
    lane_mask  = '1;
    case (d_cache_data_type)
      ONE_BYTE: begin
        lane_shift = {req_offset, 3'b000};
        lane_mask  = LEN'(8'hFF);
      end
      TWO_BYTE: begin
        lane_shift = {req_offset[1], 4'b0000};
        lane_mask  = LEN'(16'hFFFF);
      end
      default: begin
        lane_shift = '0;
        lane_mask  = '1;
      end
    endcase
  end

  assign line_word   = lines[req_index];
  assign load_value  = (line_word >> lane_shift) & lane_mask;
  assign store_value = (line_word & ~(lane_mask << lane_shift)) |
                       ((cache_written_data << lane_shift) & (lane_mask << lane_shift));

  assign mem_data       = load_hit ? load_value : '0;
  assign d_cache_status = (miss || state != IDLE) ? D_CACHE_STALL : D_CACHE_RESTING;

  always_comb begin
    state_next = state;
    ram_req    = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    case (state)
      IDLE: begin
        if (miss)
          state_next = (valid[req_index] && dirty[req_index]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        ram_req   = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = {tags[miss_index], miss_index};
        ram_wdata = lines[miss_index];
        if (ram_ready) state_next = REFILL;
      end
      REFILL: begin
        ram_req  = 1'b1;
        ram_addr = {miss_tag, miss_index};
        if (ram_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The miss target is latched so a withdrawn request still installs its line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      miss_tag   <= '0;
      miss_index <= '0;
    end else begin
      state <= state_next;
      if (miss) begin
        miss_tag   <= req_tag;
        miss_index <= req_index;
      end
      if (store_hit) dirty[req_index] <= 1'b1;
      if (state == WRITEBACK && ram_ready) dirty[miss_index] <= 1'b0;
      if (state == REFILL && ram_ready) begin
        valid[miss_index] <= 1'b1;
        dirty[miss_index] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store_hit) lines[req_index] <= store_value;
    if (state == REFILL && ram_ready) begin
      lines[miss_index] <= ram_rdata;
      tags[miss_index]  <= miss_tag;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: flat-memory reference model, cycle compare process,
// randomized RAM latencies and a few hand-computed directed scenarios.
module tb_data_cache;
  localparam logic [2:0] ONE_BYTE  = 3'd0;
  localparam logic [2:0] TWO_BYTE  = 3'd1;
  localparam logic [2:0] FOUR_BYTE = 3'd2;
  localparam logic [1:0] NOP   = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cache_vis_signal = NOP;
  logic [16:0] mem_vis_addr = '0;
  logic [2:0]  d_cache_data_type = FOUR_BYTE;
  logic [31:0] cache_written_data = '0;
  logic [3:0]  write_length = '0;
  logic [31:0] mem_data;
  logic [1:0]  d_cache_status;
  logic        ram_req, ram_we;
  logic [14:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ready = 1'b0;

  data_cache dut (
    .clk(clk), .rst_n(rst_n), .cache_vis_signal(cache_vis_signal),
    .mem_vis_addr(mem_vis_addr), .d_cache_data_type(d_cache_data_type),
    .cache_written_data(cache_written_data), .write_length(write_length),
    .mem_data(mem_data), .d_cache_status(d_cache_status), .ram_req(ram_req),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Main memory behind the cache, and the controller-visible memory contents.
  logic [31:0] ram_mem [int];
  logic [31:0] gold [int];

  function automatic logic [31:0] ram_init(int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction
  function automatic logic [31:0] ram_rd(int w);
    return ram_mem.exists(w) ? ram_mem[w] : ram_init(w);
  endfunction
  function automatic logic [31:0] gold_rd(int w);
    return gold.exists(w) ? gold[w] : ram_rd(w);
  endfunction
  function automatic logic [31:0] extract(logic [31:0] w, logic [2:0] t, int off);
    case (t)
      ONE_BYTE: return (w >> (off * 8)) & 32'hFF;
      TWO_BYTE: return (w >> ((off / 2) * 16)) & 32'hFFFF;
      default:  return w;
    endcase
  endfunction
  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [2:0] t, int off);
    logic [31:0] m;
    int sh;
    case (t)
      ONE_BYTE: begin sh = off * 8; m = 32'hFF << sh; end
      TWO_BYTE: begin sh = (off / 2) * 16; m = 32'hFFFF << sh; end
      default:  begin sh = 0; m = 32'hFFFF_FFFF; end
    endcase
    return (old & ~m) | ((d << sh) & m);
  endfunction

  // Reference model: which lines are resident/dirty and what miss is in flight.
  int m_phase = 0;  // 0 none, 1 writing back victim, 2 refilling
  bit m_valid [16];
  bit m_dirty [16];
  int m_tag [16];
  int m_idx = 0, m_vtag = 0, m_rtag = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0;
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
      gold.delete();
    end else begin
      case (m_phase)
        0: if (cache_vis_signal == LOAD || cache_vis_signal == STORE) begin
          int a, idx, tg, wd;
          a = int'(mem_vis_addr); idx = (a >> 2) & 15; tg = a >> 6; wd = a >> 2;
          if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            m_idx = idx; m_rtag = tg;
            if (m_valid[idx] && m_dirty[idx]) begin m_vtag = m_tag[idx]; m_phase = 1; end
            else m_phase = 2;
          end else if (cache_vis_signal == STORE) begin
            gold[wd] = merge(gold_rd(wd), cache_written_data, d_cache_data_type, a & 3);
            m_dirty[idx] = 1;
          end
        end
        1: if (ram_ready) begin m_dirty[m_idx] = 0; m_phase = 2; end
        2: if (ram_ready) begin
          m_valid[m_idx] = 1; m_dirty[m_idx] = 0; m_tag[m_idx] = m_rtag; m_phase = 0;
        end
        default: m_phase = 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      logic [31:0] e_data, e_addr, e_wdata;
      logic [1:0]  e_status;
      logic        e_req, e_we;
      int a, idx, tg;
      e_data = 0; e_addr = 0; e_wdata = 0; e_status = 0; e_req = 0; e_we = 0;
      a = int'(mem_vis_addr); idx = (a >> 2) & 15; tg = a >> 6;
      if (rst_n) begin
        case (m_phase)
          0: if (cache_vis_signal == LOAD || cache_vis_signal == STORE) begin
            if (m_valid[idx] && m_tag[idx] == tg) begin
              if (cache_vis_signal == LOAD)
                e_data = extract(gold_rd(a >> 2), d_cache_data_type, a & 3);
            end else e_status = 1;
          end
          1: begin
            e_status = 1; e_req = 1; e_we = 1;
            e_addr = 32'(m_vtag * 16 + m_idx);
            e_wdata = gold_rd(m_vtag * 16 + m_idx);
          end
          default: begin
            e_status = 1; e_req = 1;
            e_addr = 32'(m_rtag * 16 + m_idx);
          end
        endcase
      end
      chk("mem_data", mem_data, e_data);
      chk("status", 32'(d_cache_status), 32'(e_status));
      chk("ram_req", 32'(ram_req), 32'(e_req));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_addr", 32'(ram_addr), e_addr);
      chk("ram_wdata", ram_wdata, e_wdata);
    end
  end

  // RAM responder: ready pulses on the lat-th cycle of each request phase.
  int lat_wb = 1, lat_rf = 1, cnt = 0;
  bit rand_lat = 0, spurious_en = 0;
  int rd_cnt = 0, wr_cnt = 0, last_rd = -1, last_wr = -1;
  logic [31:0] last_wr_data = '0;
  time rd_time = 0, wr_time = 0;

  task automatic maybe_fire();
    if (cnt >= (ram_we ? lat_wb : lat_rf)) begin
      ram_ready = 1'b1;
      if (ram_we) begin
        ram_mem[int'(ram_addr)] = ram_wdata;
        wr_cnt++; last_wr = int'(ram_addr); last_wr_data = ram_wdata; wr_time = $time;
      end else begin
        ram_rdata = ram_rd(int'(ram_addr));
        rd_cnt++; last_rd = int'(ram_addr); rd_time = $time;
      end
      if (rand_lat) begin lat_wb = $urandom_range(1, 4); lat_rf = $urandom_range(1, 4); end
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      ram_ready = 1'b0; ram_rdata = '0; cnt = 0;
    end else if (ram_ready) begin
      ram_ready = 1'b0; ram_rdata = '0; cnt = 0;
      if (ram_req) begin cnt = 1; maybe_fire(); end
    end else if (ram_req) begin
      cnt++; maybe_fire();
    end else if (spurious_en && $urandom_range(0, 7) == 0) begin
      ram_ready = 1'b1; ram_rdata = $urandom;
    end
  end

  task automatic drive(input logic [1:0] s, input logic [16:0] a, input logic [2:0] t,
                       input logic [31:0] d);
    @(posedge clk); #1;
    cache_vis_signal = s; mem_vis_addr = a; d_cache_data_type = t;
    cache_written_data = d; write_length = 4'($urandom_range(0, 15));
  endtask

  task automatic do_req(input logic [1:0] s, input logic [16:0] a, input logic [2:0] t,
                        input logic [31:0] d, output int stalls, output logic [31:0] data);
    bit done;
    drive(s, a, t, d);
    stalls = 0; data = '0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (d_cache_status == 2'd0) begin data = mem_data; done = 1; end
      else stalls++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL req_timeout: got=stalled expected=resting addr=%h", a);
    end
  endtask

  initial begin
    #300000;
    bad++; total++;
    $display("FAIL global_timeout: got=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int st, r0, w0;
    logic [31:0] d;
    ram_mem[32'h10] = 32'hDEADBEEF;
    #1 cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_status", 32'(d_cache_status), 0);
    chk("reset_req", 32'(ram_req), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    lat_rf = 3; r0 = rd_cnt;
    do_req(LOAD, 17'h0040, FOUR_BYTE, 0, st, d);
    chk("cold_stalls", 32'(st), 4);
    chk("cold_data", d, 32'hDEADBEEF);
    chk("cold_reads", 32'(rd_cnt - r0), 1);
    chk("cold_rd_addr", 32'(last_rd), 32'h10);

    r0 = rd_cnt;
    do_req(LOAD, 17'h0041, ONE_BYTE, 0, st, d);
    chk("byte_hit", d, 32'h000000BE);
    chk("byte_stalls", 32'(st), 0);
    do_req(LOAD, 17'h0042, TWO_BYTE, 0, st, d);
    chk("half_hit", d, 32'h0000DEAD);
    chk("hit_no_reads", 32'(rd_cnt - r0), 0);

    w0 = wr_cnt;
    do_req(STORE, 17'h0040, TWO_BYTE, 32'h1234, st, d);
    chk("store_stalls", 32'(st), 0);
    do_req(LOAD, 17'h0040, FOUR_BYTE, 0, st, d);
    chk("store_readback", d, 32'hDEAD1234);
    chk("store_no_traffic", 32'((rd_cnt - r0) + (wr_cnt - w0)), 0);

    lat_wb = 2; lat_rf = 3; r0 = rd_cnt; w0 = wr_cnt;
    do_req(LOAD, 17'h0080, FOUR_BYTE, 0, st, d);
    chk("evict_stalls", 32'(st), 6);
    chk("evict_data", d, ram_init(32'h20));
    chk("evict_writes", 32'(wr_cnt - w0), 1);
    chk("evict_wr_addr", 32'(last_wr), 32'h10);
    chk("evict_wr_data", last_wr_data, 32'hDEAD1234);
    chk("evict_rd_addr", 32'(last_rd), 32'h20);
    chk("evict_order", 32'(wr_time < rd_time), 1);

    lat_rf = 4; r0 = rd_cnt;
    drive(LOAD, 17'h0100, FOUR_BYTE, 0);
    repeat (2) @(negedge clk);
    drive(NOP, 17'h0100, FOUR_BYTE, 0);
    for (int c = 0; c < 20 && ram_req; c++) @(negedge clk);
    chk("withdraw_reads", 32'(rd_cnt - r0), 1);
    do_req(LOAD, 17'h0100, FOUR_BYTE, 0, st, d);
    chk("withdraw_hit_stalls", 32'(st), 0);
    chk("withdraw_data", d, ram_init(32'h40));
    chk("withdraw_no_reread", 32'(rd_cnt - r0), 1);

    do_req(STORE, 17'h0100, FOUR_BYTE, 32'hCAFEF00D, st, d);
    lat_wb = 5; w0 = wr_cnt;
    drive(LOAD, 17'h0040, FOUR_BYTE, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0; cache_vis_signal = NOP;
    #1;
    chk("rst_mid_req", 32'(ram_req), 0);
    chk("rst_mid_status", 32'(d_cache_status), 0);
    chk("rst_mid_addr", 32'(ram_addr), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lat_rf = 2; r0 = rd_cnt;
    do_req(LOAD, 17'h0040, FOUR_BYTE, 0, st, d);
    chk("post_rst_stalls", 32'(st), 3);
    chk("post_rst_data", d, 32'hDEAD1234);
    chk("post_rst_no_wb", 32'(wr_cnt - w0), 0);
    do_req(LOAD, 17'h0100, FOUR_BYTE, 0, st, d);
    chk("dirty_discarded", d, ram_init(32'h40));

    rand_lat = 1; spurious_en = 1;
    for (int n = 0; n < 300; n++) begin
      logic [16:0] a;
      logic [1:0]  s;
      logic [2:0]  t;
      a = 17'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      t = 3'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0, 1:    s = NOP;
        2, 3, 4: s = STORE;
        default: s = LOAD;
      endcase
      do_req(s, a, t, $urandom, st, d);
    end

    spurious_en = 0;
    drive(NOP, '0, FOUR_BYTE, 0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
